// File: rtl/bcd_scan_display_pkg.sv
// Shared segment codes and digit-slot indices for the multiplexed temperature display.
// All segment codes are active-low {g,f,e,d,c,b,a}.
package bcd_scan_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_C     = 7'h46;

    typedef enum logic [1:0] {
        DIG_UNITS = 2'd0,
        DIG_TENS  = 2'd1,
        DIG_HUND  = 2'd2,
        DIG_UNIT  = 2'd3
    } digit_e;

    function automatic logic nibble_invalid(input logic [3:0] nib);
        return nib > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment code; non-decimal nibbles show a dash.
module bcd_to_seg7
    import bcd_scan_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_DASH;
        case (nibble)
            4'd0: seg_n = 7'h40;
            4'd1: seg_n = 7'h79;
            4'd2: seg_n = 7'h24;
            4'd3: seg_n = 7'h30;
            4'd4: seg_n = 7'h19;
            4'd5: seg_n = 7'h12;
            4'd6: seg_n = 7'h02;
            4'd7: seg_n = 7'h78;
            4'd8: seg_n = 7'h00;
            4'd9: seg_n = 7'h10;
            default: seg_n = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// 4-digit multiplexed common-anode scan of a 3-digit BCD temperature plus 'C' symbol.
// New values are staged in pending and only reach the display at a frame boundary.
module bcd_scan_display
    import bcd_scan_display_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] bcd_in,
    input  logic        bcd_valid,
    input  logic        blank_en,
    input  logic        show_unit,
    output logic [6:0]  seg_n,
    output logic [3:0]  an_n,
    output logic        dp_n,
    output logic        frame_tick,
    output logic        bcd_err
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    digit_e        digit_sel_q, digit_sel_d;
    logic [11:0]   pending_q, pending_d;
    logic [11:0]   display_q, display_d;
    logic [6:0]    seg_n_q, seg_n_d;
    logic [3:0]    an_n_q, an_n_d;
    logic          frame_tick_q, frame_tick_d;
    logic          bcd_err_q, bcd_err_d;

    logic          slot_wrap, frame_end;
    logic [3:0]    digit_nib;
    logic [6:0]    digit_seg;
    logic          disp_err, hund_blank, tens_blank;

    assign slot_wrap = (div_cnt_q == DIV_LAST);
    assign frame_end = slot_wrap && (digit_sel_q == DIG_UNIT);

    always_comb begin
        div_cnt_d    = slot_wrap ? '0 : div_cnt_q + 1'b1;
        digit_sel_d  = slot_wrap ? digit_e'(digit_sel_q + 2'd1) : digit_sel_q;
        pending_d    = bcd_valid ? bcd_in : pending_q;
        display_d    = frame_end ? pending_q : display_q;
        frame_tick_d = frame_end;
    end

    always_comb begin
        digit_nib = 4'h0;
        case (digit_sel_q)
            DIG_UNITS: digit_nib = display_q[3:0];
            DIG_TENS:  digit_nib = display_q[7:4];
            DIG_HUND:  digit_nib = display_q[11:8];
            DIG_UNIT:  digit_nib = 4'h0;
        endcase
    end

    bcd_to_seg7 u_bcd_to_seg7 (
        .nibble (digit_nib),
        .seg_n  (digit_seg)
    );

    // An invalid nibble anywhere dashes all numeric digits, overriding blanking.
    assign disp_err   = nibble_invalid(display_q[11:8]) || nibble_invalid(display_q[7:4])
                     || nibble_invalid(display_q[3:0]);
    assign hund_blank = blank_en && (display_q[11:8] == 4'h0);
    assign tens_blank = hund_blank && (display_q[7:4] == 4'h0);

    always_comb begin
        seg_n_d = SEG_BLANK;
        case (digit_sel_q)
            DIG_UNITS: seg_n_d = disp_err ? SEG_DASH : digit_seg;
            DIG_TENS:  seg_n_d = disp_err ? SEG_DASH : (tens_blank ? SEG_BLANK : digit_seg);
            DIG_HUND:  seg_n_d = disp_err ? SEG_DASH : (hund_blank ? SEG_BLANK : digit_seg);
            DIG_UNIT:  seg_n_d = show_unit ? SEG_C : SEG_BLANK;
        endcase
        an_n_d = 4'hF;
        if (div_cnt_q >= BLANK_END) begin
            an_n_d = ~(4'b0001 << digit_sel_q);
        end
        bcd_err_d = disp_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q    <= '0;
            digit_sel_q  <= DIG_UNITS;
            pending_q    <= '0;
            display_q    <= '0;
            seg_n_q      <= SEG_BLANK;
            an_n_q       <= 4'hF;
            frame_tick_q <= 1'b0;
            bcd_err_q    <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            digit_sel_q  <= digit_sel_d;
            pending_q    <= pending_d;
            display_q    <= display_d;
            seg_n_q      <= seg_n_d;
            an_n_q       <= an_n_d;
            frame_tick_q <= frame_tick_d;
            bcd_err_q    <= bcd_err_d;
        end
    end

    assign seg_n      = seg_n_q;
    assign an_n       = an_n_q;
    assign dp_n       = 1'b1;
    assign frame_tick = frame_tick_q;
    assign bcd_err    = bcd_err_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench: the driver predicts each cycle's outputs from a cycle-count model and queues them.
module tb_bcd_scan_display;

    localparam int R     = 8;
    localparam int B     = 2;
    localparam int FRAME = 4 * R;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] bcd_in;
    logic        bcd_valid;
    logic        blank_en;
    logic        show_unit;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        dp_n;
    logic        frame_tick;
    logic        bcd_err;

    always #5 clk = ~clk;

    bcd_scan_display #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
        .clk        (clk),
        .reset      (reset),
        .bcd_in     (bcd_in),
        .bcd_valid  (bcd_valid),
        .blank_en   (blank_en),
        .show_unit  (show_unit),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .dp_n       (dp_n),
        .frame_tick (frame_tick),
        .bcd_err    (bcd_err)
    );

    typedef struct {
        logic [6:0] seg;
        logic [3:0] an;
        logic       tick;
        logic       err;
        logic       chk_seg;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state: cycles since reset, staged and shown values.
    int          t_m    = 0;
    logic [11:0] pend_m = 12'h000;
    logic [11:0] disp_m = 12'h000;
    logic        be_s   = 1'b1;
    logic        su_s   = 1'b0;
    logic [11:0] junk   = 12'h000;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic logic has_bad(input logic [11:0] d);
        return (d[11:8] > 4'd9) || (d[7:4] > 4'd9) || (d[3:0] > 4'd9);
    endfunction

    function automatic logic [6:0] digit_code(input int slot, input logic [11:0] d,
                                              input logic be, input logic su);
        int h, tn, u;
        h  = int'(d[11:8]);
        tn = int'(d[7:4]);
        u  = int'(d[3:0]);
        if (slot == 3) return su ? 7'h46 : 7'h7F;
        if (has_bad(d)) return 7'h3F;
        if (slot == 0) return seg_tab[u];
        if (slot == 1) return (be && h == 0 && tn == 0) ? 7'h7F : seg_tab[tn];
        return (be && h == 0) ? 7'h7F : seg_tab[h];
    endfunction

    task automatic chk(input string nm, input logic [6:0] got, input logic [6:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, got, want);
        end
    endtask

    // Drive one cycle of inputs, predict the outputs after the coming edge, advance the model.
    task automatic step(input logic r, input logic v, input logic [11:0] d);
        exp_t e;
        int   slot, phase;
        reset     = r;
        bcd_valid = v;
        bcd_in    = d;
        blank_en  = be_s;
        show_unit = su_s;
        if (r) begin
            e.seg = 7'h7F; e.an = 4'hF; e.tick = 1'b0; e.err = 1'b0; e.chk_seg = 1'b1;
            t_m = 0; pend_m = 12'h000; disp_m = 12'h000;
        end else begin
            slot  = (t_m / R) % 4;
            phase = t_m % R;
            e.an  = 4'hF;
            if (phase >= B) e.an[slot] = 1'b0;
            e.chk_seg = (phase >= B);
            e.seg  = digit_code(slot, disp_m, be_s, su_s);
            e.err  = has_bad(disp_m);
            e.tick = ((t_m % FRAME) == FRAME - 1);
            if (e.tick) disp_m = pend_m;
            if (v) pend_m = d;
            t_m++;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            junk = 12'($urandom);
            step(1'b0, 1'b0, junk);
        end
    endtask

    task automatic idle_to(input int pos);
        for (int i = 0; i < FRAME && (t_m % FRAME) != pos; i++) idle(1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cyc++;
                chk("an_n", 7'(an_n), 7'(e.an));
                chk("frame_tick", 7'(frame_tick), 7'(e.tick));
                chk("bcd_err", 7'(bcd_err), 7'(e.err));
                chk("dp_n", 7'(dp_n), 7'd1);
                if (e.chk_seg) chk("seg_n", seg_n, e.seg);
            end
        end
    end

    initial begin : driver
        reset = 1'b1; bcd_valid = 1'b0; bcd_in = 12'h000; blank_en = 1'b1; show_unit = 1'b0;
        // Reset, release, first frame shows a blanked zero.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 12'h000);
        idle(40);
        // Mid-frame strobe is held back until the next frame boundary.
        idle_to(10);
        step(1'b0, 1'b1, 12'h245);
        idle(70);
        // Leading-zero blanking on and off.
        step(1'b0, 1'b1, 12'h007);
        idle(70);
        be_s = 1'b0;
        idle(40);
        be_s = 1'b1;
        // Invalid nibble, then recovery.
        step(1'b0, 1'b1, 12'h0A3);
        idle(70);
        step(1'b0, 1'b1, 12'h103);
        idle(70);
        // Strobe coinciding with the frame boundary lands one frame later.
        idle_to(5);
        step(1'b0, 1'b1, 12'h222);
        idle_to(FRAME - 1);
        step(1'b0, 1'b1, 12'h111);
        idle(70);
        // Unit symbol on and off, then reset in the middle of slot 3.
        su_s = 1'b1;
        idle(40);
        su_s = 1'b0;
        idle(40);
        su_s = 1'b1;
        idle_to(28);
        step(1'b1, 1'b0, 12'h000);
        idle(10);
        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            logic [11:0] d;
            if ($urandom_range(0, 3) == 0) d = 12'($urandom);
            else d = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 49) == 0) be_s = ~be_s;
            if ($urandom_range(0, 49) == 0) su_s = ~su_s;
            if ($urandom_range(0, 299) == 0) step(1'b1, 1'b0, d);
            else step(1'b0, ($urandom_range(0, 19) == 0), d);
        end
        repeat (2) @(posedge clk);
        #3;
        chk("drain", 7'(exp_q.size()), 7'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
